alu_multicycle: RTL and testbench

//   Parametrised successor of the 32-bit execute-stage ALU.

---
 rtl/alu_multicycle.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with single-cycle logic/arithmetic ops and
// iterative unsigned multiply, divide and remainder. Operands enter through a
// valid/ready handshake; the registered result is offered through a second
// valid/ready handshake and held until the consumer takes it.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  // Iteration counter spans exactly WIDTH steps (0 .. WIDTH-1).
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic add_overflow(input logic sign_a, input logic sign_b,
                                        input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

  // Signed overflow of a - b: operands differ in sign, result differs from a.
  function automatic logic sub_overflow(input logic sign_a, input logic sign_b,
                                        input logic sign_r);
    return (sign_a != sign_b) && (sign_r != sign_a);
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic               accept_s;

  // Latched operation and iteration state
  logic [2:0]         op_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   acc_r;       // partial product
  logic [WIDTH-1:0]   mcand_r;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_r;    // multiplier, shifted right each step
  logic [WIDTH-1:0]   rem_r;       // partial remainder
  logic [WIDTH-1:0]   quo_r;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   divisor_r;

  // Registered outputs
  logic [WIDTH-1:0]   result_r;
  logic               zero_r;
  logic               overflow_r;
  logic               dbz_r;

  // Single-cycle datapath
  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic               slt_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_ovf_s;
  logic               alu_dbz_s;

  // Iterative datapath
  logic               last_iter_s;
  logic [WIDTH-1:0]   mul_acc_s;
  logic [WIDTH:0]     rem_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [WIDTH-1:0]   div_quo_s;

  assign sum_s  = a + b;
  assign diff_s = a - b;
  assign slt_s  = ($signed(a) < $signed(b));

  assign last_iter_s = (cnt_r == CNT_LAST);

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set; only the low WIDTH bits of the product are kept.
  assign mul_acc_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  // One restoring-division step: bring down the next dividend bit and subtract
  // the divisor if it fits. The extra top bit of rem_shift_s keeps the compare
  // exact; the difference itself always fits in WIDTH bits.
  assign rem_shift_s = {rem_r, quo_r[WIDTH-1]};
  assign div_ge_s    = (rem_shift_s >= {1'b0, divisor_r});
  assign div_rem_s   = div_ge_s ? (rem_shift_s[WIDTH-1:0] - divisor_r)
                                : rem_shift_s[WIDTH-1:0];
  assign div_quo_s   = {quo_r[WIDTH-2:0], div_ge_s};

  // Result and flags of every op that completes in the accept cycle,
  // including the divide-by-zero cases of DIVU/REMU.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    alu_dbz_s = 1'b0;
    case (op)
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = add_overflow(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = sub_overflow(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
      OP_DIVU: begin
        alu_res_s = {WIDTH{1'b1}};
        alu_dbz_s = 1'b1;
      end
      OP_REMU: begin
        alu_res_s = a;
        alu_dbz_s = 1'b1;
      end
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        alu_dbz_s = 1'b0;
      end
    endcase
  end

  // Next-state decode and accept strobe; input is taken only in IDLE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          case (op)
            OP_MUL: state_s = ST_MUL;
            OP_DIVU, OP_REMU: begin
              if (b == {WIDTH{1'b0}}) begin
                state_s = ST_DONE;
              end else begin
                state_s = ST_DIV;
              end
            end
            default: state_s = ST_DONE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (last_iter_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_DIV: begin
        if (last_iter_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DIV;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r       <= 3'b000;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      mcand_r    <= {WIDTH{1'b0}};
      mplier_r   <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      zero_r     <= 1'b0;
      overflow_r <= 1'b0;
      dbz_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r      <= op;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            mcand_r   <= a;
            mplier_r  <= b;
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= a;
            divisor_r <= b;
            if (state_s == ST_DONE) begin
              result_r   <= alu_res_s;
              zero_r     <= (alu_res_s == {WIDTH{1'b0}});
              overflow_r <= alu_ovf_s;
              dbz_r      <= alu_dbz_s;
            end
          end
        end
        ST_MUL: begin
          acc_r    <= mul_acc_s;
          mcand_r  <= mcand_r << 1'b1;
          mplier_r <= mplier_r >> 1'b1;
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_iter_s) begin
            result_r   <= mul_acc_s;
            zero_r     <= (mul_acc_s == {WIDTH{1'b0}});
            overflow_r <= 1'b0;
            dbz_r      <= 1'b0;
          end
        end
        ST_DIV: begin
          rem_r <= div_rem_s;
          quo_r <= div_quo_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_iter_s) begin
            if (op_r == OP_REMU) begin
              result_r <= div_rem_s;
              zero_r   <= (div_rem_s == {WIDTH{1'b0}});
            end else begin
              result_r <= div_quo_s;
              zero_r   <= (div_quo_s == {WIDTH{1'b0}});
            end
            overflow_r <= 1'b0;
            dbz_r      <= 1'b0;
          end
        end
        default: begin
          // DONE: result and flags held until the consumer takes them
          result_r <= result_r;
        end
      endcase
    end
  end

  assign in_ready    = (state_r == ST_IDLE);
  assign out_valid   = (state_r == ST_DONE);
  assign result      = result_r;
  assign zero        = zero_r;
  assign overflow    = overflow_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table-driven directed vectors, hand-written handshake and
// reset sequences, and randomized ops checked against an arithmetic model, on
// a 32-bit and an 8-bit instance of alu_multicycle.
module tb_alu_multicycle;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel8 = 1'b0;
  logic        drive_valid = 1'b0;
  logic        drive_out_ready = 1'b1;
  logic [31:0] drive_a = 32'd0;
  logic [31:0] drive_b = 32'd0;
  logic [2:0]  drive_op = 3'd0;

  logic        in_valid32, in_ready32, out_valid32, zero32, ovf32, dbz32;
  logic [31:0] result32;
  logic        in_valid8, in_ready8, out_valid8, zero8, ovf8, dbz8;
  logic [7:0]  result8;

  logic        cur_in_ready, cur_out_valid, cur_zero, cur_ovf, cur_dbz;
  logic [31:0] cur_result;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign in_valid32 = drive_valid & ~sel8;
  assign in_valid8  = drive_valid & sel8;

  assign cur_in_ready  = sel8 ? in_ready8  : in_ready32;
  assign cur_out_valid = sel8 ? out_valid8 : out_valid32;
  assign cur_result    = sel8 ? {24'd0, result8} : result32;
  assign cur_zero      = sel8 ? zero8 : zero32;
  assign cur_ovf       = sel8 ? ovf8  : ovf32;
  assign cur_dbz       = sel8 ? dbz8  : dbz32;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(drive_a), .b(drive_b), .op(drive_op), .out_valid(out_valid32),
    .out_ready(drive_out_ready), .result(result32), .zero(zero32),
    .overflow(ovf32), .div_by_zero(dbz32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(drive_a[7:0]), .b(drive_b[7:0]), .op(drive_op), .out_valid(out_valid8),
    .out_ready(drive_out_ready), .result(result8), .zero(zero8),
    .overflow(ovf8), .div_by_zero(dbz8)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        d;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic z,
                              input logic o, input logic d, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res;
    v.z = z; v.o = o; v.d = d; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain wide arithmetic on values masked to w bits.
  function automatic void model(input int w, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output logic z,
                                output logic o, output logic d, output int lat);
    longint unsigned mask, ua, ub, res;
    longint sa, sb, t, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    smax = longint'(mask >> 1);
    smin = -smax - 64'sd1;
    sa = (((ua >> (w - 1)) & 64'd1) != 0) ? longint'(ua) - longint'(mask) - 64'sd1 : longint'(ua);
    sb = (((ub >> (w - 1)) & 64'd1) != 0) ? longint'(ub) - longint'(mask) - 64'sd1 : longint'(ub);
    o = 1'b0; d = 1'b0; lat = 1; res = 64'd0;
    case (op)
      OP_AND: res = ua & ub;
      OP_OR:  res = ua | ub;
      OP_ADD: begin res = (ua + ub) & mask; t = sa + sb; o = (t > smax) || (t < smin); end
      OP_SUB: begin res = (ua - ub) & mask; t = sa - sb; o = (t > smax) || (t < smin); end
      OP_MUL: begin res = (ua * ub) & mask; lat = w + 1; end
      OP_DIVU: if (ub == 0) begin res = mask; d = 1'b1; end else begin res = ua / ub; lat = w + 1; end
      OP_REMU: if (ub == 0) begin res = ua; d = 1'b1; end else begin res = ua % ub; lat = w + 1; end
      OP_SLT: res = (sa < sb) ? 64'd1 : 64'd0;
      default: res = 64'd0;
    endcase
    r = res[31:0];
    z = (res == 64'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Issue one op, wait for its result, check latency/result/flags, optionally
  // hold out_ready low for 'hold' cycles, then retire it and check IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input logic eo, input logic ed, input int elat, input int hold);
    int n;
    int busy_bad;
    int hold_bad;
    n = 0;
    while (!cur_in_ready && n < 100) begin tick(); n++; end
    chk({tag, ".ready"}, {31'd0, cur_in_ready}, 32'd1);
    drive_op = op; drive_a = a; drive_b = b;
    drive_valid = 1'b1;
    drive_out_ready = (hold == 0);
    tick();
    drive_valid = 1'b0;
    drive_a = $urandom; drive_b = $urandom; drive_op = 3'($urandom_range(0, 7));
    n = 1; busy_bad = 0;
    while (!cur_out_valid && n < 200) begin
      if (cur_in_ready) busy_bad++;
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".busy"}, busy_bad, 32'd0);
    chk({tag, ".res"}, cur_result, er);
    chk({tag, ".zero"}, {31'd0, cur_zero}, {31'd0, ez});
    chk({tag, ".ovf"}, {31'd0, cur_ovf}, {31'd0, eo});
    chk({tag, ".dbz"}, {31'd0, cur_dbz}, {31'd0, ed});
    if (hold > 0) begin
      hold_bad = 0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!cur_out_valid || cur_in_ready || cur_result !== er) hold_bad++;
      end
      chk({tag, ".hold"}, hold_bad, 32'd0);
      drive_out_ready = 1'b1;
    end
    tick();
    chk({tag, ".retire_valid"}, {31'd0, cur_out_valid}, 32'd0);
    chk({tag, ".retire_ready"}, {31'd0, cur_in_ready}, 32'd1);
  endtask

  vec_t vecs[16];

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb, er;
    logic        ez, eo, ed;
    int          elat, cnt;

    vecs[0]  = mk("add_ovf",  OP_ADD,  32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1);
    vecs[1]  = mk("sub_eq",   OP_SUB,  32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1);
    vecs[2]  = mk("slt_neg",  OP_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1);
    vecs[3]  = mk("mul",      OP_MUL,  32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0, 1'b0, 33);
    vecs[4]  = mk("divu",     OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 33);
    vecs[5]  = mk("remu",     OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 33);
    vecs[6]  = mk("divu_z",   OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1);
    vecs[7]  = mk("remu_z",   OP_REMU, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1, 1);
    vecs[8]  = mk("and",      OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1);
    vecs[9]  = mk("or",       OP_OR,   32'h0F0F0000, 32'h00F000F0, 32'h0FFF00F0, 1'b0, 1'b0, 1'b0, 1);
    vecs[10] = mk("sub_ovf",  OP_SUB,  32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1);
    vecs[11] = mk("and_zero", OP_AND,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'd0, 1'b1, 1'b0, 1'b0, 1);
    vecs[12] = mk("mul_wrap", OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 33);
    vecs[13] = mk("slt_pos",  OP_SLT,  32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0, 1);
    vecs[14] = mk("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1);
    vecs[15] = mk("divu_lt",  OP_DIVU, 32'd7, 32'd100, 32'd0, 1'b1, 1'b0, 1'b0, 33);

    // Reset held for two cycles
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset.in_ready", {31'd0, in_ready32}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid32}, 32'd0);
    chk("reset.result", result32, 32'd0);
    chk("reset.flags", {29'd0, zero32, ovf32, dbz32}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].z, vecs[i].o, vecs[i].d, vecs[i].lat, 0);
    end

    // Back-to-back single-cycle ops, out_ready high: one result per 2 cycles
    drive_op = OP_ADD; drive_a = 32'd3; drive_b = 32'd4;
    drive_out_ready = 1'b1; drive_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid32) cnt++;
    end
    drive_valid = 1'b0;
    chk("b2b.count", cnt, 32'd10);
    chk("b2b.result", result32, 32'd7);
    tick();

    // DONE held with out_ready low while upstream already presents the next op
    drive_op = OP_SUB; drive_a = 32'd10; drive_b = 32'd3;
    drive_out_ready = 1'b0; drive_valid = 1'b1;
    tick();
    drive_op = OP_ADD; drive_a = 32'd1; drive_b = 32'd1;
    chk("hold.first_valid", {31'd0, out_valid32}, 32'd1);
    chk("hold.first_res", result32, 32'd7);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid32 || in_ready32 || result32 !== 32'd7) cnt++;
    end
    chk("hold.stable", cnt, 32'd0);
    drive_out_ready = 1'b1;
    tick();
    chk("hold.release_valid", {31'd0, out_valid32}, 32'd0);
    chk("hold.release_ready", {31'd0, in_ready32}, 32'd1);
    tick();
    drive_valid = 1'b0;
    chk("hold.next_valid", {31'd0, out_valid32}, 32'd1);
    chk("hold.next_res", result32, 32'd2);
    tick();

    // Reset asserted during MUL iteration: operation abandoned
    drive_op = OP_MUL; drive_a = 32'd1000; drive_b = 32'd1000; drive_valid = 1'b1;
    tick();
    drive_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.in_ready", {31'd0, in_ready32}, 32'd1);
    chk("midrst.out_valid", {31'd0, out_valid32}, 32'd0);
    chk("midrst.result", result32, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid32) cnt++;
    end
    chk("midrst.no_result", cnt, 32'd0);
    chk("midrst.idle", {31'd0, in_ready32}, 32'd1);

    // Randomized ops on the 32-bit instance
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 300));
        2: rb = ra;
        default: rb = $urandom;
      endcase
      model(32, rop, ra, rb, er, ez, eo, ed, elat);
      run_op($sformatf("rnd32_%0d", i), rop, ra, rb, er, ez, eo, ed, elat,
             int'($urandom_range(0, 2)));
    end

    // 8-bit instance: directed then randomized
    sel8 = 1'b1;
    tick();
    run_op("w8_mul",    OP_MUL,  32'd13,  32'd11, 32'd143, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op("w8_divu",   OP_DIVU, 32'd200, 32'd9,  32'd22,  1'b0, 1'b0, 1'b0, 9, 0);
    run_op("w8_remu",   OP_REMU, 32'd200, 32'd9,  32'd2,   1'b0, 1'b0, 1'b0, 9, 0);
    run_op("w8_divu_z", OP_DIVU, 32'd5,   32'd0,  32'hFF,  1'b0, 1'b0, 1'b1, 1, 0);
    run_op("w8_add",    OP_ADD,  32'h7F,  32'd1,  32'h80,  1'b0, 1'b1, 1'b0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 32'($urandom_range(0, 255));
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      model(8, rop, ra, rb, er, ez, eo, ed, elat);
      run_op($sformatf("rnd8_%0d", i), rop, ra, rb, er, ez, eo, ed, elat,
             int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
